// File: rtl/intersection_scheduler.sv
// Two-road intersection light scheduler.
// Six-phase cycle (main green, main yellow, all-red, country green, country
// yellow, all-red) driven by a per-phase 6-bit timer, road demand levels and
// a level-held emergency request with acknowledge.
module intersection_scheduler #(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW_T  = 4,
  parameter int ALLRED_T  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] main_traffic,
  input  logic [2:0] country_traffic,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic [1:0] mainLight,
  output logic [1:0] countryLight,
  output logic [2:0] phase,
  output logic       emg_ack
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    AR_M2C = 3'd2,
    CTRY_G = 3'd3,
    CTRY_Y = 3'd4,
    AR_C2M = 3'd5
  } state_t;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;

  // Timer thresholds are "last cycle" indices, since the timer reads 0 on entry.
  localparam logic [5:0] MIN_LAST = 6'(MIN_GREEN - 1);
  localparam logic [5:0] MAX_LAST = 6'(MAX_GREEN - 1);
  localparam logic [5:0] YEL_LAST = 6'(YELLOW_T - 1);
  localparam logic [5:0] AR_LAST  = 6'(ALLRED_T - 1);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_timer;
  logic [5:0] w_timer_next;
  logic [1:0] r_main_light;
  logic [1:0] r_ctry_light;
  logic       r_ack;
  logic       w_ack_next;

  logic w_emg_main;
  logic w_emg_ctry;
  logic w_emg_release;
  logic w_main_yield;
  logic w_ctry_yield;

  function automatic logic [5:0] sat_inc(input logic [5:0] t);
    return (t == 6'd63) ? t : t + 6'd1;
  endfunction

  function automatic logic [1:0] main_light_of(input state_t s);
    case (s)
      MAIN_G:  return L_GREEN;
      MAIN_Y:  return L_YELLOW;
      default: return L_RED;
    endcase
  endfunction

  function automatic logic [1:0] ctry_light_of(input state_t s);
    case (s)
      CTRY_G:  return L_GREEN;
      CTRY_Y:  return L_YELLOW;
      default: return L_RED;
    endcase
  endfunction

  assign w_emg_main    = emg_req && !emg_dir;
  assign w_emg_ctry    = emg_req &&  emg_dir;
  // First cycle after the requester lets go: hold green once and restart the
  // timer so the saturated emergency count does not force an instant yield.
  assign w_emg_release = r_ack && !emg_req;

  assign w_main_yield = ((r_timer >= MIN_LAST) && (country_traffic > main_traffic)) ||
                        ((r_timer >= MAX_LAST) && (country_traffic != 3'd0));
  assign w_ctry_yield = ((r_timer >= MIN_LAST) &&
                         ((country_traffic == 3'd0) || (main_traffic > country_traffic))) ||
                        ((r_timer >= MAX_LAST) && (main_traffic != 3'd0));

  // Next-state and emergency acknowledge decision.
  always_comb begin
    w_next     = r_state;
    w_ack_next = 1'b0;
    case (r_state)
      MAIN_G: begin
        if (w_emg_main)                        w_ack_next = 1'b1;
        else if (w_emg_ctry)                   w_next = MAIN_Y;
        else if (!w_emg_release && w_main_yield) w_next = MAIN_Y;
      end
      MAIN_Y: if (r_timer == YEL_LAST) w_next = AR_M2C;
      AR_M2C: if (r_timer == AR_LAST)  w_next = CTRY_G;
      CTRY_G: begin
        if (w_emg_ctry)                        w_ack_next = 1'b1;
        else if (w_emg_main)                   w_next = CTRY_Y;
        else if (!w_emg_release && w_ctry_yield) w_next = CTRY_Y;
      end
      CTRY_Y: if (r_timer == YEL_LAST) w_next = AR_C2M;
      AR_C2M: if (r_timer == AR_LAST)  w_next = MAIN_G;
      default: w_next = AR_C2M;
    endcase
  end

  // Timer clears on state entry or emergency release, otherwise saturates up.
  always_comb begin
    w_timer_next = sat_inc(r_timer);
    if ((w_next != r_state) || w_emg_release) w_timer_next = 6'd0;
  end

  // State, timer, lights and acknowledge registers; lights track the new state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= MAIN_G;
      r_timer      <= 6'd0;
      r_main_light <= L_GREEN;
      r_ctry_light <= L_RED;
      r_ack        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_timer      <= w_timer_next;
      r_main_light <= main_light_of(w_next);
      r_ctry_light <= ctry_light_of(w_next);
      r_ack        <= w_ack_next;
    end
  end

  assign mainLight    = r_main_light;
  assign countryLight = r_ctry_light;
  assign phase        = r_state;
  assign emg_ack      = r_ack;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: directed phase sequences push
// expected outputs; a negedge monitor pops them and also checks light safety
// and phase ordering every cycle, including a long randomized run.
module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] main_traffic;
  logic [2:0] country_traffic;
  logic       emg_req;
  logic       emg_dir;
  logic [1:0] mainLight;
  logic [1:0] countryLight;
  logic [2:0] phase;
  logic       emg_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] ml;
    logic [1:0] cl;
    logic [2:0] ph;
    logic       ack;
    string      name;
  } exp_t;

  exp_t sb[$];

  intersection_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .main_traffic   (main_traffic),
    .country_traffic(country_traffic),
    .emg_req        (emg_req),
    .emg_dir        (emg_dir),
    .mainLight      (mainLight),
    .countryLight   (countryLight),
    .phase          (phase),
    .emg_ack        (emg_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] exp_main(input int p);
    if (p == 0) return 2'b10;
    if (p == 1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [1:0] exp_ctry(input int p);
    if (p == 3) return 2'b10;
    if (p == 4) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] p);
    if (p == 3'd5) return 3'd0;
    if (p > 3'd5)  return 3'd5;
    return p + 3'd1;
  endfunction

  // Expect phase p with acknowledge a for the current and next n-1 cycles.
  task automatic expect_n(input int p, input logic a, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.ml   = exp_main(p);
      e.cl   = exp_ctry(p);
      e.ph   = 3'(p);
      e.ack  = a;
      e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: scoreboard compare plus per-cycle safety invariants.
  initial begin
    logic [2:0] prev_ph;
    exp_t e;
    prev_ph = 3'd0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (mainLight !== e.ml || countryLight !== e.cl || phase !== e.ph || emg_ack !== e.ack) begin
          errors++;
          $display("FAIL %s t=%0t: got main=%b ctry=%b phase=%0d ack=%b, want main=%b ctry=%b phase=%0d ack=%b",
                   e.name, $time, mainLight, countryLight, phase, emg_ack, e.ml, e.cl, e.ph, e.ack);
        end
      end
      checks++;
      if (mainLight === 2'b11 || countryLight === 2'b11 ||
          (mainLight !== 2'b00 && countryLight !== 2'b00)) begin
        errors++;
        $display("FAIL light_safety t=%0t: got main=%b ctry=%b, want one red and no 11",
                 $time, mainLight, countryLight);
      end
      checks++;
      if (emg_ack === 1'b1 && phase !== 3'd0 && phase !== 3'd3) begin
        errors++;
        $display("FAIL ack_non_green t=%0t: got ack=1 in phase %0d, want 0", $time, phase);
      end
      if (!rst) begin
        checks++;
        if (phase !== prev_ph && phase !== succ(prev_ph)) begin
          errors++;
          $display("FAIL phase_order t=%0t: got %0d after %0d, want %0d or %0d",
                   $time, phase, prev_ph, prev_ph, succ(prev_ph));
        end
      end
      prev_ph = phase;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t", $time);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    main_traffic = 3'd0;
    country_traffic = 3'd0;
    emg_req = 1'b0;
    emg_dir = 1'b0;
    @(posedge clk);
    #1;
    expect_n(0, 0, 2, "reset_state");

    // Demand 2 vs 5: 8 green, 4 yellow, 2 all-red, country green.
    rst = 1'b0;
    main_traffic = 3'd2;
    country_traffic = 3'd5;
    expect_n(0, 0, 8, "min_green_main");
    expect_n(1, 0, 4, "yellow_main");
    expect_n(2, 0, 2, "allred_m2c");
    // Country holds against weaker main demand until max green.
    expect_n(3, 0, 32, "max_green_ctry");
    expect_n(4, 0, 4, "yellow_ctry");
    expect_n(5, 0, 2, "allred_c2m");

    // Equal demand: both greens run to max green.
    main_traffic = 3'd3;
    country_traffic = 3'd3;
    expect_n(0, 0, 32, "equal_main_g");
    expect_n(1, 0, 4, "equal_main_y");
    expect_n(2, 0, 2, "equal_ar");
    expect_n(3, 0, 32, "equal_ctry_g");
    expect_n(4, 0, 4, "equal_ctry_y");
    expect_n(5, 0, 2, "equal_ar2");

    // No country demand: main stays green indefinitely.
    main_traffic = 3'd7;
    country_traffic = 3'd0;
    expect_n(0, 0, 200, "main_hold");

    // Reset mid-green, then emergency toward country at timer 2.
    rst = 1'b1;
    expect_n(0, 0, 2, "reset_in_green");
    rst = 1'b0;
    expect_n(0, 0, 2, "pre_emg_green");
    emg_req = 1'b1;
    emg_dir = 1'b1;
    expect_n(0, 0, 1, "emg_seen");
    expect_n(1, 0, 4, "emg_yellow");
    expect_n(2, 0, 2, "emg_allred");
    expect_n(3, 0, 1, "emg_green_entry");
    expect_n(3, 1, 70, "emg_hold");
    emg_req = 1'b0;
    expect_n(3, 1, 1, "emg_release_cycle");
    expect_n(3, 0, 8, "emg_timer_restart");
    expect_n(4, 0, 1, "ctry_yellow_pre_rst");

    // Asynchronous reset in the middle of country yellow.
    rst = 1'b1;
    expect_n(0, 0, 2, "async_rst_yellow");

    // Emergency toward main while in main green, then reset under it.
    rst = 1'b0;
    main_traffic = 3'd0;
    country_traffic = 3'd0;
    emg_req = 1'b1;
    emg_dir = 1'b0;
    expect_n(0, 0, 1, "emg_main_first");
    expect_n(0, 1, 3, "emg_main_ack");
    rst = 1'b1;
    expect_n(0, 0, 1, "rst_mid_emg");
    emg_req = 1'b0;
    rst = 1'b0;
    expect_n(0, 0, 2, "after_emg_rst");

    // Randomized traffic and emergencies; invariants only.
    for (int c = 0; c < 20000; c++) begin
      if (c % 16 == 0) begin
        main_traffic = 3'($urandom_range(0, 7));
        country_traffic = 3'($urandom_range(0, 7));
      end
      if (!emg_req) begin
        if ($urandom_range(0, 199) == 0) begin
          emg_dir = 1'($urandom_range(0, 1));
          emg_req = 1'b1;
        end
      end else if (emg_ack && $urandom_range(0, 19) == 0) begin
        emg_req = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    emg_req = 1'b0;

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
